multi_frame_aligner: RTL and testbench

MULTI_FRAME_ALIGNER -- requirements
Module: multi_frame_aligner

---
 rtl/frame_align_pkg.sv | 24 ++
 rtl/multi_frame_aligner_if.sv | 31 +++
 rtl/frame_align_chan.sv | 113 +++++++++++
 rtl/tmr_voter.sv | 13 +
 rtl/multi_frame_aligner.sv | 122 ++++++++++++
 tb/tb_multi_frame_aligner.sv | 181 ++++++++++++++++++
 6 files changed

// File: rtl/frame_align_pkg.sv
// Shared types and helpers for the multi-channel frame aligner.
package frame_align_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Slip counter width for a power-of-two frame size.
  function automatic int calc_slip_w(input int frame_size);
    return $clog2(frame_size);
  endfunction

  // A marker is good when only bit 0 of the rotated sof is set.
  // Frames are at most 16 bits, so callers zero-extend to 16.
  function automatic logic good_marker(input logic [15:0] sof);
    return sof == 16'd1;
  endfunction

endpackage

// File: rtl/multi_frame_aligner_if.sv
// Bus bundle for multi_frame_aligner: raw frames in, aligned frames and status out.
interface multi_frame_aligner_if
  import frame_align_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int FRAME_SIZE   = 8
);
  localparam int SLIP_W = calc_slip_w(FRAME_SIZE);

  logic [NUM_CHANNELS*FRAME_SIZE-1:0] data_i;
  logic [NUM_CHANNELS*FRAME_SIZE-1:0] sof_i;
  logic [NUM_CHANNELS-1:0]            channel_mask_i;
  logic [CNT_W-1:0]                   aligned_count_to_ready;
  logic [NUM_CHANNELS*FRAME_SIZE-1:0] data_o;
  logic [NUM_CHANNELS*SLIP_W-1:0]     bitslip_cnt_o;
  logic [NUM_CHANNELS-1:0]            aligned_o;
  logic [NUM_CHANNELS-1:0]            unstable_o;
  logic                               all_aligned_o;
  logic [15:0]                        tmr_err_cnt_o;

  modport master (
    output data_i, sof_i, channel_mask_i, aligned_count_to_ready,
    input  data_o, bitslip_cnt_o, aligned_o, unstable_o, all_aligned_o, tmr_err_cnt_o
  );

  modport slave (
    input  data_i, sof_i, channel_mask_i, aligned_count_to_ready,
    output data_o, bitslip_cnt_o, aligned_o, unstable_o, all_aligned_o, tmr_err_cnt_o
  );

endinterface

// File: rtl/frame_align_chan.sv
// One aligner channel: rotator plus SEARCH/CONFIRM/LOCKED FSM with lock counter.
// Next state is computed from the *_i copies of the state so that a voted
// value can be fed back when the channel is replicated.
module frame_align_chan
  import frame_align_pkg::*;
#(
  parameter int  FRAME_SIZE = 8,
  localparam int SLIP_W     = calc_slip_w(FRAME_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset_i,
  input  logic [FRAME_SIZE-1:0] data_i,
  input  logic [FRAME_SIZE-1:0] sof_i,
  input  logic                  mask_i,
  input  logic [CNT_W-1:0]      ready_i,
  input  state_t                st_i,
  input  logic [SLIP_W-1:0]     slip_i,
  input  logic [CNT_W-1:0]      cnt_i,
  input  logic                  unst_i,
  output state_t                st_o,
  output logic [SLIP_W-1:0]     slip_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  unst_o,
  output logic [FRAME_SIZE-1:0] rot_o
);
  state_t              st_q, st_d;
  logic [SLIP_W-1:0]   slip_q, slip_d, idx;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                unst_q, unst_d, good;
  logic [FRAME_SIZE-1:0] rot_sof;

  // Rotate data and sof by the current slip: rot[k] = in[(k+slip) mod FRAME_SIZE].
  always_comb begin
    rot_o   = '0;
    rot_sof = '0;
    idx     = '0;
    for (int k = 0; k < FRAME_SIZE; k++) begin
      idx        = SLIP_W'(k) + slip_i;
      rot_o[k]   = data_i[idx];
      rot_sof[k] = sof_i[idx];
    end
  end

  assign good = good_marker(16'(rot_sof));

  // Next-state logic. CONFIRM compares the count held before this marker,
  // so a threshold of N locks on the N-th good CONFIRM cycle (0 and 1 both
  // lock on the first one).
  always_comb begin
    st_d   = st_i;
    slip_d = slip_i;
    cnt_d  = cnt_i;
    unst_d = unst_i;
    if (mask_i) begin
      st_d   = SEARCH;
      slip_d = '0;
      cnt_d  = '0;
    end else begin
      case (st_i)
        SEARCH: begin
          if (good) begin
            st_d  = CONFIRM;
            cnt_d = CNT_W'(1);
          end else begin
            slip_d = slip_i + SLIP_W'(1);
          end
        end
        CONFIRM: begin
          if (good) begin
            cnt_d = (cnt_i == CNT_MAX) ? CNT_MAX : cnt_i + CNT_W'(1);
            if (cnt_i >= ready_i) st_d = LOCKED;
          end else begin
            st_d   = SEARCH;
            slip_d = slip_i + SLIP_W'(1);
            cnt_d  = '0;
          end
        end
        LOCKED: begin
          if (!good) begin
            st_d   = SEARCH;
            cnt_d  = '0;
            unst_d = 1'b1;
          end
        end
        default: begin
          st_d  = SEARCH;
          cnt_d = '0;
        end
      endcase
    end
  end

  // FSM, slip, counter and sticky unstable registers.
  always_ff @(posedge clock) begin
    if (reset_i) begin
      st_q   <= SEARCH;
      slip_q <= '0;
      cnt_q  <= '0;
      unst_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      slip_q <= slip_d;
      cnt_q  <= cnt_d;
      unst_q <= unst_d;
    end
  end

  assign st_o   = st_q;
  assign slip_o = slip_q;
  assign cnt_o  = cnt_q;
  assign unst_o = unst_q;

endmodule

// File: rtl/tmr_voter.sv
// Bitwise 2-of-3 majority voter with a disagreement flag.
module tmr_voter #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] y_o,
  output logic         err_o
);
  assign y_o   = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign err_o = |((a_i ^ b_i) | (a_i ^ c_i));
endmodule

// File: rtl/multi_frame_aligner.sv
// Multi-channel elink frame aligner. Optional triplicated channel state with
// majority voting is enabled by defining TMR_FRAME_ALIGNER_EN.
module multi_frame_aligner
  import frame_align_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int FRAME_SIZE   = 8
) (
  input logic                  clock,
  input logic                  reset_i,
  multi_frame_aligner_if.slave bus
);
  localparam int SLIP_W = calc_slip_w(FRAME_SIZE);

  typedef logic [NUM_CHANNELS-1:0][FRAME_SIZE-1:0] frame_vec_t;

  frame_vec_t data_in, sof_in, rot_d, rot_q, data_d, data_q;
  logic [NUM_CHANNELS-1:0][SLIP_W-1:0] slip_v, slip_q;
  logic [NUM_CHANNELS-1:0] lock_v, unst_v, aligned_d, aligned_q, unst_q;
  logic all_d, all_q;

  assign data_in = bus.data_i;
  assign sof_in  = bus.sof_i;

`ifdef TMR_FRAME_ALIGNER_EN
  logic [NUM_CHANNELS-1:0] vote_err;
  logic [15:0]             err_cnt_q;
`endif

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
`ifdef TMR_FRAME_ALIGNER_EN
    localparam int VW = 2 + SLIP_W + CNT_W + 1;
    logic [2:0][VW-1:0]         rep;
    logic [2:0][FRAME_SIZE-1:0] rot_rep;
    logic [VW-1:0]              voted;
    state_t                     st_v;
    logic [CNT_W-1:0]           cnt_v;
    for (genvar r = 0; r < 3; r++) begin : g_rep
      state_t            st_r;
      logic [SLIP_W-1:0] slip_r;
      logic [CNT_W-1:0]  cnt_r;
      logic              unst_r;
      frame_align_chan #(.FRAME_SIZE(FRAME_SIZE)) u_chan (
        .clock(clock), .reset_i(reset_i), .data_i(data_in[c]), .sof_i(sof_in[c]),
        .mask_i(bus.channel_mask_i[c]), .ready_i(bus.aligned_count_to_ready),
        .st_i(st_v), .slip_i(slip_v[c]), .cnt_i(cnt_v), .unst_i(unst_v[c]),
        .st_o(st_r), .slip_o(slip_r), .cnt_o(cnt_r), .unst_o(unst_r),
        .rot_o(rot_rep[r])
      );
      assign rep[r] = {st_r, slip_r, cnt_r, unst_r};
    end
    tmr_voter #(.W(VW)) u_vote (
      .a_i(rep[0]), .b_i(rep[1]), .c_i(rep[2]), .y_o(voted), .err_o(vote_err[c])
    );
    assign st_v      = state_t'(voted[VW-1 -: 2]);
    assign slip_v[c] = voted[CNT_W+1 +: SLIP_W];
    assign cnt_v     = voted[1 +: CNT_W];
    assign unst_v[c] = voted[0];
    assign rot_d[c]  = (rot_rep[0] & rot_rep[1]) | (rot_rep[0] & rot_rep[2]) |
                       (rot_rep[1] & rot_rep[2]);
    assign lock_v[c] = (st_v == LOCKED);
`else
    state_t           st_w;
    logic [CNT_W-1:0] cnt_w;
    frame_align_chan #(.FRAME_SIZE(FRAME_SIZE)) u_chan (
      .clock(clock), .reset_i(reset_i), .data_i(data_in[c]), .sof_i(sof_in[c]),
      .mask_i(bus.channel_mask_i[c]), .ready_i(bus.aligned_count_to_ready),
      .st_i(st_w), .slip_i(slip_v[c]), .cnt_i(cnt_w), .unst_i(unst_v[c]),
      .st_o(st_w), .slip_o(slip_v[c]), .cnt_o(cnt_w), .unst_o(unst_v[c]),
      .rot_o(rot_d[c])
    );
    assign lock_v[c] = (st_w == LOCKED);
`endif
  end

  // Output gating: masked channels report no data and no lock.
  always_comb begin
    data_d = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      data_d[c] = bus.channel_mask_i[c] ? '0 : rot_q[c];
    end
    aligned_d = lock_v & ~bus.channel_mask_i;
    all_d     = ~(&bus.channel_mask_i) & (&(aligned_d | bus.channel_mask_i));
  end

  // Two-stage data pipeline (rotate, output) and registered status.
  always_ff @(posedge clock) begin
    if (reset_i) begin
      rot_q     <= '0;
      data_q    <= '0;
      slip_q    <= '0;
      aligned_q <= '0;
      unst_q    <= '0;
      all_q     <= 1'b0;
    end else begin
      rot_q     <= rot_d;
      data_q    <= data_d;
      slip_q    <= slip_v;
      aligned_q <= aligned_d;
      unst_q    <= unst_v;
      all_q     <= all_d;
    end
  end

`ifdef TMR_FRAME_ALIGNER_EN
  // Saturating count of cycles where any channel's replicas disagree.
  always_ff @(posedge clock) begin
    if (reset_i)                             err_cnt_q <= '0;
    else if (|vote_err && err_cnt_q != '1)   err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign bus.tmr_err_cnt_o = err_cnt_q;
`else
  assign bus.tmr_err_cnt_o = '0;
`endif

  assign bus.data_o        = data_q;
  assign bus.bitslip_cnt_o = slip_q;
  assign bus.aligned_o     = aligned_q;
  assign bus.unstable_o    = unst_q;
  assign bus.all_aligned_o = all_q;

endmodule

// File: tb/tb_multi_frame_aligner.sv
// Directed bench for multi_frame_aligner (8 channels x 8 bits).
module tb_multi_frame_aligner;
  logic clock = 1'b0;
  logic reset_i;
  int   total = 0;
  int   bad   = 0;

  multi_frame_aligner_if #(.NUM_CHANNELS(8), .FRAME_SIZE(8)) bus ();

  multi_frame_aligner #(.NUM_CHANNELS(8), .FRAME_SIZE(8)) dut (
    .clock(clock), .reset_i(reset_i), .bus(bus)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic set_in(input logic [63:0] d, input logic [63:0] s,
                        input logic [7:0] m, input logic [11:0] r);
    bus.data_i                 = d;
    bus.sof_i                  = s;
    bus.channel_mask_i         = m;
    bus.aligned_count_to_ready = r;
  endtask

  task automatic do_reset;
    reset_i = 1'b1;
    tick(2);
    reset_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    set_in('1, '1, 8'h00, 12'd0);
    tick(2);
    total++; if (bus.data_o !== 64'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.data_o); end
    total++; if (bus.aligned_o !== 8'h00) begin bad++; $display("FAIL reset_aligned: got %h want 00", bus.aligned_o); end
    total++; if (bus.unstable_o !== 8'h00) begin bad++; $display("FAIL reset_unstable: got %h want 00", bus.unstable_o); end
    total++; if (bus.bitslip_cnt_o !== 24'h0) begin bad++; $display("FAIL reset_slip: got %h want 0", bus.bitslip_cnt_o); end
    total++; if (bus.all_aligned_o !== 1'b0) begin bad++; $display("FAIL reset_all: got %b want 0", bus.all_aligned_o); end
    total++; if (bus.tmr_err_cnt_o !== 16'h0) begin bad++; $display("FAIL reset_tmr: got %h want 0", bus.tmr_err_cnt_o); end
    reset_i = 1'b0;
  endtask

  // ch0 marker at bit 3: slip walks 0..3, then four good CONFIRM cycles.
  task automatic test_slip_lock;
    set_in(64'h0, 64'h08, 8'h00, 12'd4);
    do_reset;
    tick(3);
    total++; if (bus.bitslip_cnt_o[2:0] !== 3'd2) begin bad++; $display("FAIL slip_step: got %0d want 2", bus.bitslip_cnt_o[2:0]); end
    tick(1);
    total++; if (bus.bitslip_cnt_o[2:0] !== 3'd3) begin bad++; $display("FAIL slip_found: got %0d want 3", bus.bitslip_cnt_o[2:0]); end
    tick(4);
    total++; if (bus.aligned_o[0] !== 1'b0) begin bad++; $display("FAIL lock_early: got %b want 0", bus.aligned_o[0]); end
    tick(1);
    total++; if (bus.aligned_o[0] !== 1'b1) begin bad++; $display("FAIL lock_ch0: got %b want 1", bus.aligned_o[0]); end
    total++; if (bus.all_aligned_o !== 1'b0) begin bad++; $display("FAIL all_partial: got %b want 0", bus.all_aligned_o); end
    bus.data_i = 64'hA5;
    tick(1);
    total++; if (bus.data_o[7:0] !== 8'h00) begin bad++; $display("FAIL data_latency: got %h want 00", bus.data_o[7:0]); end
    tick(1);
    total++; if (bus.data_o[7:0] !== 8'hB4) begin bad++; $display("FAIL data_rot3: got %h want b4", bus.data_o[7:0]); end
    total++; if (bus.bitslip_cnt_o[2:0] !== 3'd3) begin bad++; $display("FAIL slip_hold: got %0d want 3", bus.bitslip_cnt_o[2:0]); end
  endtask

  // ch2 locks at slip 0, loses one marker, then relocks.
  task automatic test_relock;
    set_in(64'h0, 64'h0001_0000, 8'h00, 12'd2);
    do_reset;
    tick(3);
    total++; if (bus.aligned_o[2] !== 1'b0) begin bad++; $display("FAIL relock_pre: got %b want 0", bus.aligned_o[2]); end
    tick(1);
    total++; if (bus.aligned_o[2] !== 1'b1) begin bad++; $display("FAIL relock_lock: got %b want 1", bus.aligned_o[2]); end
    total++; if (bus.unstable_o[2] !== 1'b0) begin bad++; $display("FAIL relock_unst0: got %b want 0", bus.unstable_o[2]); end
    bus.sof_i = 64'h0;
    tick(1);
    bus.sof_i = 64'h0001_0000;
    tick(1);
    total++; if (bus.aligned_o[2] !== 1'b0) begin bad++; $display("FAIL relock_drop: got %b want 0", bus.aligned_o[2]); end
    total++; if (bus.unstable_o[2] !== 1'b1) begin bad++; $display("FAIL relock_unst: got %b want 1", bus.unstable_o[2]); end
    total++; if (bus.bitslip_cnt_o[8:6] !== 3'd0) begin bad++; $display("FAIL relock_slip: got %0d want 0", bus.bitslip_cnt_o[8:6]); end
    tick(3);
    total++; if (bus.aligned_o[2] !== 1'b1) begin bad++; $display("FAIL relock_again: got %b want 1", bus.aligned_o[2]); end
    total++; if (bus.unstable_o[2] !== 1'b1) begin bad++; $display("FAIL relock_sticky: got %b want 1", bus.unstable_o[2]); end
  endtask

  // Only ch0 enabled, threshold 0; then every channel masked.
  task automatic test_mask;
    set_in(64'hFFFF_FFFF_FFFF_FF3C, 64'h01, 8'hFE, 12'd0);
    do_reset;
    tick(2);
    total++; if (bus.aligned_o !== 8'h00) begin bad++; $display("FAIL mask_pre: got %h want 00", bus.aligned_o); end
    total++; if (bus.all_aligned_o !== 1'b0) begin bad++; $display("FAIL mask_all_pre: got %b want 0", bus.all_aligned_o); end
    tick(1);
    total++; if (bus.aligned_o !== 8'h01) begin bad++; $display("FAIL mask_lock: got %h want 01", bus.aligned_o); end
    total++; if (bus.all_aligned_o !== 1'b1) begin bad++; $display("FAIL mask_all: got %b want 1", bus.all_aligned_o); end
    total++; if (bus.data_o !== 64'h3C) begin bad++; $display("FAIL mask_data: got %h want 3c", bus.data_o); end
    bus.channel_mask_i = 8'hFF;
    tick(2);
    total++; if (bus.all_aligned_o !== 1'b0) begin bad++; $display("FAIL maskall_all: got %b want 0", bus.all_aligned_o); end
    total++; if (bus.aligned_o !== 8'h00) begin bad++; $display("FAIL maskall_aligned: got %h want 00", bus.aligned_o); end
    total++; if (bus.data_o !== 64'h0) begin bad++; $display("FAIL maskall_data: got %h want 0", bus.data_o); end
  endtask

  // Threshold 4095 on ch1: locks on the 4095th good CONFIRM cycle.
  task automatic test_count_max;
    set_in(64'h0, 64'h0100, 8'hFD, 12'd4095);
    do_reset;
    tick(4096);
    total++; if (bus.aligned_o[1] !== 1'b0) begin bad++; $display("FAIL max_early: got %b want 0", bus.aligned_o[1]); end
    tick(1);
    total++; if (bus.aligned_o[1] !== 1'b1) begin bad++; $display("FAIL max_lock: got %b want 1", bus.aligned_o[1]); end
    tick(5);
    total++; if (bus.aligned_o[1] !== 1'b1) begin bad++; $display("FAIL max_hold: got %b want 1", bus.aligned_o[1]); end
    total++; if (bus.unstable_o[1] !== 1'b0) begin bad++; $display("FAIL max_unst: got %b want 0", bus.unstable_o[1]); end
  endtask

  // Reset applied while every channel is locked.
  task automatic test_reset_locked;
    set_in({8{8'h5A}}, {8{8'h01}}, 8'h00, 12'd1);
    do_reset;
    tick(3);
    total++; if (bus.aligned_o !== 8'hFF) begin bad++; $display("FAIL rl_locked: got %h want ff", bus.aligned_o); end
    total++; if (bus.all_aligned_o !== 1'b1) begin bad++; $display("FAIL rl_all: got %b want 1", bus.all_aligned_o); end
    total++; if (bus.data_o !== {8{8'h5A}}) begin bad++; $display("FAIL rl_data: got %h want 5a..", bus.data_o); end
    reset_i = 1'b1;
    tick(1);
    total++; if (bus.aligned_o !== 8'h00) begin bad++; $display("FAIL rl_rst_aligned: got %h want 00", bus.aligned_o); end
    total++; if (bus.all_aligned_o !== 1'b0) begin bad++; $display("FAIL rl_rst_all: got %b want 0", bus.all_aligned_o); end
    total++; if (bus.data_o !== 64'h0) begin bad++; $display("FAIL rl_rst_data: got %h want 0", bus.data_o); end
    reset_i = 1'b0;
    tick(1);
    total++; if (bus.aligned_o !== 8'h00) begin bad++; $display("FAIL rl_search: got %h want 00", bus.aligned_o); end
    tick(2);
    total++; if (bus.aligned_o !== 8'hFF) begin bad++; $display("FAIL rl_relock: got %h want ff", bus.aligned_o); end
  endtask

`ifdef TMR_FRAME_ALIGNER_EN
  // Corrupt replica 1 slip of ch5 for three cycles; voting must hide it.
  task automatic test_tmr;
    set_in(64'h0, 64'h0000_0100_0000_0000, 8'hDF, 12'd1);
    do_reset;
    tick(3);
    force dut.g_ch[5].g_rep[1].slip_r = 3'd3;
    tick(3);
    release dut.g_ch[5].g_rep[1].slip_r;
    tick(1);
    total++; if (bus.bitslip_cnt_o[17:15] !== 3'd0) begin bad++; $display("FAIL tmr_slip: got %0d want 0", bus.bitslip_cnt_o[17:15]); end
    total++; if (bus.aligned_o[5] !== 1'b1) begin bad++; $display("FAIL tmr_aligned: got %b want 1", bus.aligned_o[5]); end
    total++; if (bus.tmr_err_cnt_o !== 16'd3) begin bad++; $display("FAIL tmr_cnt: got %0d want 3", bus.tmr_err_cnt_o); end
  endtask
`else
  task automatic test_tmr_tied;
    total++; if (bus.tmr_err_cnt_o !== 16'd0) begin bad++; $display("FAIL tmr_tied: got %0d want 0", bus.tmr_err_cnt_o); end
  endtask
`endif

  initial begin
    reset_i = 1'b1;
    test_reset;
    test_slip_lock;
    test_relock;
    test_mask;
    test_count_max;
    test_reset_locked;
`ifdef TMR_FRAME_ALIGNER_EN
    test_tmr;
`else
    test_tmr_tied;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
